// File: rtl/cnn_fmap_serializer_pkg.sv
// rtl/cnn_fmap_serializer_pkg.sv - shared geometry constants for the CNN fmap serializer and packer
package cnn_fmap_serializer_pkg;

    localparam int DEF_IN         = 2;
    localparam int DEF_OCH        = 3;
    localparam int DEF_OX         = 4;
    localparam int DEF_OY         = 4;
    localparam int DEF_DATA_LEN   = 8;
    localparam int DEF_FMAP_WORDS = DEF_OCH * DEF_OX * DEF_OY;
    localparam int DEF_NWORDS     = DEF_IN * DEF_FMAP_WORDS;

    // A single-word frame still needs a one-bit index.
    function automatic int idx_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/cnn_fmap_word_sel.sv
// rtl/cnn_fmap_word_sel.sv - combinational select of one word from a flat frame bus
module cnn_fmap_word_sel
    import cnn_fmap_serializer_pkg::*;
#(
    parameter int NWORDS   = DEF_NWORDS,
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int IDX_W    = idx_width(NWORDS)
) (
    input  logic [NWORDS*DATA_LEN-1:0] bus,
    input  logic [IDX_W-1:0]           idx,
    output logic [DATA_LEN-1:0]        word
);

    // Indices past the last word read as zero rather than out-of-range slices.
    always_comb begin
        word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (idx == IDX_W'(k)) begin
                word = bus[k*DATA_LEN +: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/cnn_fmap_serializer.sv
// rtl/cnn_fmap_serializer.sv - captures a full batch result and streams it out word by word
module cnn_fmap_serializer
    import cnn_fmap_serializer_pkg::*;
#(
    parameter int IN         = DEF_IN,
    parameter int OCH        = DEF_OCH,
    parameter int OX         = DEF_OX,
    parameter int OY         = DEF_OY,
    parameter int DATA_LEN   = DEF_DATA_LEN,
    localparam int FMAP_WORDS = OCH * OX * OY,
    localparam int NWORDS     = IN * FMAP_WORDS,
    localparam int IDX_W      = idx_width(NWORDS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_soft_reset,
    input  logic                       i_in_valid,
    input  logic [NWORDS*DATA_LEN-1:0] i_in_fmap,
    output logic                       o_in_ready,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_LEN-1:0]        o_data,
    output logic [IDX_W-1:0]           o_word_idx,
    output logic                       o_last_fmap,
    output logic                       o_last,
    output logic                       o_busy,
    output logic                       o_overrun
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       capture;
    logic                       advance;
    logic                       in_ready;
    logic [NWORDS*DATA_LEN-1:0] shadow;
    logic [IDX_W-1:0]           idx_next;
    logic [DATA_LEN-1:0]        word_next;
    logic                       last_next;
    logic                       last_fmap_next;

    assign o_in_ready = in_ready;
    assign idx_next   = o_word_idx + IDX_W'(1);

    cnn_fmap_word_sel #(
        .NWORDS   (NWORDS),
        .DATA_LEN (DATA_LEN),
        .IDX_W    (IDX_W)
    ) u_word_sel (
        .bus  (shadow),
        .idx  (idx_next),
        .word (word_next)
    );

    always_comb begin
        last_next      = (idx_next == IDX_W'(NWORDS - 1));
        last_fmap_next = (((int'(idx_next) + 1) % FMAP_WORDS) == 0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // o_last is registered alongside idx, so it doubles as the idx==NWORDS-1 test.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (i_in_valid) begin
                    capture    = 1'b1;
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready = o_last & i_ready;
                if (i_ready) begin
                    if (!o_last) begin
                        advance = 1'b1;
                    end else if (i_in_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (i_soft_reset) begin
            state_next = S_IDLE;
            capture    = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow      <= '0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
            o_word_idx  <= '0;
            o_data      <= '0;
            o_last      <= 1'b0;
            o_last_fmap <= 1'b0;
        end else if (i_soft_reset) begin
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
            o_word_idx  <= '0;
            o_data      <= '0;
            o_last      <= 1'b0;
            o_last_fmap <= 1'b0;
        end else begin
            o_valid <= (state_next == S_STREAM);
            o_busy  <= (state_next == S_STREAM);
            if (capture) begin
                shadow      <= i_in_fmap;
                o_word_idx  <= '0;
                o_data      <= i_in_fmap[DATA_LEN-1:0];
                o_last      <= (NWORDS == 1);
                o_last_fmap <= (FMAP_WORDS == 1);
            end else if (advance) begin
                o_word_idx  <= idx_next;
                o_data      <= word_next;
                o_last      <= last_next;
                o_last_fmap <= last_fmap_next;
            end
            if (i_in_valid && !in_ready) begin
                o_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cnn_fmap_serializer.md
Name: cnn_fmap_serializer

Overview:
- Output-side counterpart of the CNN top core's wide-bus interface.
- Captures one complete batch result (IN*OCH*OX*OY words, flat bus) on a single-cycle valid pulse.
- Streams the result out one DATA_LEN word per handshake over valid/ready, toward the DMA/AXI-stream writer.
- Tags each word with batch/channel/position indices and end-of-fmap and end-of-frame markers.

Parameters:
IN, 2, batch count (fmaps per frame)
OCH, 3, output channels per fmap
OX, 4, output width
OY, 4, output height
DATA_LEN, 8, bits per word
NWORDS, IN*OCH*OX*OY (derived localparam), words per frame
IDX_W, $clog2(NWORDS) (derived localparam), index width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_soft_reset  in  1  synchronous clear, priority over all other inputs
i_in_valid  in  1  one-cycle pulse: i_in_fmap holds a complete frame
i_in_fmap  in  NWORDS*DATA_LEN  frame; word k = [k*DATA_LEN +: DATA_LEN]
o_in_ready  out  1  high when a new frame is accepted this cycle
o_valid  out  1  o_data is valid
i_ready  in  1  downstream accepts the word
o_data  out  DATA_LEN  current word
o_word_idx  out  IDX_W  index k of the current word
o_last_fmap  out  1  current word is the last word of one batch fmap: (k+1) % (OCH*OX*OY)==0
o_last  out  1  current word is k==NWORDS-1
o_busy  out  1  frame held, not yet fully drained
o_overrun  out  1  sticky: a frame arrived while it could not be accepted

Behaviour:
- Reset is asynchronous on reset_n. Reset values:
  - state IDLE; o_valid=0, o_busy=0, o_overrun=0, o_word_idx=0.
  - o_data, o_last, o_last_fmap = 0.
  - Shadow frame register cleared.
- i_soft_reset (sync) sets the same values as reset, except the shadow register, which keeps its contents. It overrides a simultaneous i_in_valid, and that frame is dropped without setting overrun.
- Handshake: a word transfers on a cycle with o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_data, o_word_idx, o_last and o_last_fmap hold stable.
  - o_valid never drops without a transfer, except on reset or soft reset.
- o_in_ready = (state==IDLE) | (state==STREAM & o_last & i_ready). It is combinational from state and i_ready.
- FSM, two states:
  - IDLE: o_valid=0. On i_in_valid: capture i_in_fmap into the shadow register, set idx=0, go to STREAM.
  - STREAM: o_valid=1; o_data = shadow word at idx.
    - Transfer with idx<NWORDS-1: idx+1.
    - Transfer with idx==NWORDS-1 and no i_in_valid: go to IDLE.
    - Transfer with idx==NWORDS-1 and i_in_valid in the same cycle: capture the new frame, set idx=0, stay in STREAM. This gives back-to-back frames with no bubble.
- Latency: i_in_valid sampled at edge N gives o_valid=1 and word 0 on o_data during the cycle after edge N. Steady-state throughput is 1 word/cycle when i_ready stays high.
- Overrun: i_in_valid while o_in_ready=0 sets o_overrun=1. The frame is discarded and the stream in flight is unaffected. o_overrun clears only on reset or soft reset.
- o_busy = (state==STREAM).
- o_data is driven from a registered word mux or a right-shifting shadow register; both are acceptable if port behaviour is identical.
- Index arithmetic is unsigned IDX_W bits; there is no wrap past NWORDS-1.
- All outputs come from registers, except o_in_ready.

Decomposition:
- Shared defines header:
  - IN, OCH, OX, OY, DATA_LEN defaults.
  - NWORDS and FMAP_WORDS = OCH*OX*OY constants, also shared by the top core and the matching input packer.
- State encodings are local localparams.
- One optional sub-module, cnn_fmap_word_sel: combinational select of the word at idx from the shadow bus. It is reusable by the packer's checker.

Test Plan (defaults, NWORDS=96, frame word k = k mod 256):
1. Single frame, i_ready tied 1, pulse i_in_valid at cycle 10:
   - o_valid high in cycles 11..106, o_data = 0,1,...,95.
   - o_last_fmap at k=47 and k=95; o_last only at k=95.
   - o_busy falls after cycle 106.
2. Backpressure: i_ready toggles 1,0,0,1,...:
   - o_data and o_word_idx hold stable while i_ready=0.
   - All 96 words are delivered in order; none duplicated or skipped.
3. Back-to-back: second frame (word k = 255-k) pulsed in the same cycle as the k=95 transfer:
   - o_in_ready=1 in that cycle.
   - The next cycle shows o_data=255, idx=0 with no idle cycle between frames.
4. Overrun: second i_in_valid at k=20 of frame 1:
   - o_overrun=1 from the next cycle and stays set.
   - Frame 1 completes unchanged; the second frame never appears on o_data.
5. Soft reset at k=30 with i_in_valid also high:
   - Next cycle o_valid=0, o_busy=0, idx=0, o_overrun=0.
   - No frame is captured; a later i_in_valid restarts cleanly at word 0.
6. Async reset_n low mid-stream (k=50, between clock edges):
   - Outputs go to reset values immediately.
   - After release, IDLE with o_in_ready=1.
